// File: rtl/mux_pkg.sv
// Shared select/enable encodings for the 4-to-1 multiplexer.
package mux_pkg;

   localparam logic [1:0] SEL_IN0   = 2'b00;
   localparam logic [1:0] SEL_IN1   = 2'b01;
   localparam logic [1:0] SEL_IN2   = 2'b10;
   localparam logic [1:0] SEL_IN3   = 2'b11;
   localparam logic       EN_ACTIVE = 1'b0;

endpackage : mux_pkg

// File: rtl/mux_4to1_comb.sv
// Combinational core: steers one of four inputs, or DISABLED_VALUE when disabled.
module mux_4to1_comb
   import mux_pkg::*;
#(
   parameter int unsigned           WIDTH          = 1,
   parameter logic [WIDTH-1:0]      DISABLED_VALUE = '0
) (
   input  logic             en,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = DISABLED_VALUE;
      if (en == EN_ACTIVE) begin
         case (sel)
            SEL_IN0: y = in0;
            SEL_IN1: y = in1;
            SEL_IN2: y = in2;
            SEL_IN3: y = in3;
            // unknown select propagates as X rather than being masked
            default: y = 'x;
         endcase
      end
   end

endmodule : mux_4to1_comb

// File: rtl/mux_4to1.sv
// 4-to-1 mux with active-low enable; exports both the combinational result and a registered copy.
module mux_4to1
   import mux_pkg::*;
#(
   parameter int unsigned      WIDTH          = 1,
   parameter logic [WIDTH-1:0] DISABLED_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_comb,
   input  logic             en,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in0,
   input  logic             s1,
   input  logic             s0
);

   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;

   mux_4to1_comb #(
      .WIDTH          (WIDTH),
      .DISABLED_VALUE (DISABLED_VALUE)
   ) u_comb (
      .en  (en),
      .sel ({s1, s0}),
      .in0 (in0),
      .in1 (in1),
      .in2 (in2),
      .in3 (in3),
      .y   (out_comb)
   );

   always_comb begin
      out_d = out_comb;
   end

   // reset clears to zero, not DISABLED_VALUE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: directed scenarios plus randomized traffic against an array-indexed model.
module tb_mux_4to1;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       s1;
   logic       s0;
   logic       a0, a1, a2, a3;
   logic [7:0] b0, b1, b2, b3;
   logic       o1_out, o1_comb;
   logic [7:0] o8_out, o8_comb;
   logic [3:0] o4_out, o4_comb;

   int unsigned checks;
   int unsigned failures;

   localparam logic [7:0] DIS4 = 8'h0A;

   mux_4to1 #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .out(o1_out), .out_comb(o1_comb), .en(en),
      .in3(a3), .in2(a2), .in1(a1), .in0(a0), .s1(s1), .s0(s0)
   );

   mux_4to1 #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .out(o8_out), .out_comb(o8_comb), .en(en),
      .in3(b3), .in2(b2), .in1(b1), .in0(b0), .s1(s1), .s0(s0)
   );

   mux_4to1 #(.WIDTH(4), .DISABLED_VALUE(4'hA)) u4 (
      .clk(clk), .rst_n(rst_n), .out(o4_out), .out_comb(o4_comb), .en(en),
      .in3(b3[3:0]), .in2(b2[3:0]), .in1(b1[3:0]), .in0(b0[3:0]), .s1(s1), .s0(s0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: disabled -> fixed value, otherwise index the inputs by the select number
   function automatic logic [7:0] model(input logic e, input logic [1:0] s,
                                        input logic [7:0] d0, input logic [7:0] d1,
                                        input logic [7:0] d2, input logic [7:0] d3,
                                        input logic [7:0] dis);
      logic [7:0] arr [4];
      arr[0] = d0; arr[1] = d1; arr[2] = d2; arr[3] = d3;
      return e ? dis : arr[s];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; {s1, s0} = 2'b00;
      {a3, a2, a1, a0} = 4'b1111;
      b0 = 8'hFF; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (o1_out !== 1'b0 || o8_out !== 8'h00 || o4_out !== 4'h0) begin
         failures++;
         $display("FAIL reset_out: got %b/%h/%h want 0/00/0", o1_out, o8_out, o4_out);
      end
      checks++;
      if (o1_comb !== 1'b1 || o8_comb !== 8'hFF) begin
         failures++;
         $display("FAIL reset_comb_live: got %b/%h want 1/ff", o1_comb, o8_comb);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (o8_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_release_hold: got %h want 00", o8_out);
      end
      @(posedge clk); #1;
      checks++;
      if (o8_out !== 8'hFF || o1_out !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_capture: got %h/%b want ff/1", o8_out, o1_out);
      end
   endtask

   task automatic test_toggle_track();
      logic [7:0] cnt;
      logic       exp_c;
      cnt = '0;
      en = 1'b0;
      for (int sel = 0; sel < 4; sel++) begin
         for (int k = 0; k < 16; k++) begin
            {s1, s0} = sel[1:0];
            a0 = cnt[0]; a1 = cnt[1]; a2 = cnt[2]; a3 = cnt[3];
            exp_c = cnt[sel];
            #1;
            checks++;
            if (o1_comb !== exp_c) begin
               failures++;
               $display("FAIL toggle_comb sel=%0d k=%0d: got %b want %b", sel, k, o1_comb, exp_c);
            end
            @(posedge clk); #1;
            checks++;
            if (o1_out !== exp_c) begin
               failures++;
               $display("FAIL toggle_reg sel=%0d k=%0d: got %b want %b", sel, k, o1_out, exp_c);
            end
            cnt++;
         end
      end
   endtask

   task automatic test_disabled();
      en = 1'b1;
      {a3, a2, a1, a0} = 4'b1111;
      b0 = 8'hFF; b1 = 8'hFF; b2 = 8'hFF; b3 = 8'hFF;
      for (int sel = 0; sel < 4; sel++) begin
         {s1, s0} = sel[1:0];
         #1;
         checks++;
         if (o1_comb !== 1'b0 || o8_comb !== 8'h00 || o4_comb !== 4'hA) begin
            failures++;
            $display("FAIL disabled_comb sel=%0d: got %b/%h/%h want 0/00/a", sel, o1_comb, o8_comb, o4_comb);
         end
         @(posedge clk); #1;
         checks++;
         if (o1_out !== 1'b0 || o8_out !== 8'h00 || o4_out !== 4'hA) begin
            failures++;
            $display("FAIL disabled_reg sel=%0d: got %b/%h/%h want 0/00/a", sel, o1_out, o8_out, o4_out);
         end
      end
   endtask

   task automatic test_enable_transition();
      en = 1'b0; {s1, s0} = 2'b10; a2 = 1'b1; a0 = 1'b0; a1 = 1'b0; a3 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (o1_out !== 1'b1) begin
         failures++;
         $display("FAIL en_pre: got %b want 1", o1_out);
      end
      en = 1'b1;
      #1;
      checks++;
      if (o1_comb !== 1'b0 || o1_out !== 1'b1) begin
         failures++;
         $display("FAIL en_drop_comb: got comb=%b out=%b want comb=0 out=1", o1_comb, o1_out);
      end
      @(posedge clk); #1;
      checks++;
      if (o1_out !== 1'b0) begin
         failures++;
         $display("FAIL en_drop_reg: got %b want 0", o1_out);
      end
   endtask

   task automatic test_reset_mid();
      en = 1'b0; {s1, s0} = 2'b00; a0 = 1'b1; b0 = 8'h5C;
      @(posedge clk); #1;
      checks++;
      if (o1_out !== 1'b1 || o8_out !== 8'h5C) begin
         failures++;
         $display("FAIL rstmid_pre: got %b/%h want 1/5c", o1_out, o8_out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (o1_out !== 1'b0 || o8_out !== 8'h00 || o1_comb !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_async: got out=%b/%h comb=%b want 0/00/1", o1_out, o8_out, o1_comb);
      end
      @(posedge clk); #1;
      checks++;
      if (o1_out !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_hold: got %b want 0", o1_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o1_out !== 1'b1 || o8_out !== 8'h5C) begin
         failures++;
         $display("FAIL rstmid_release: got %b/%h want 1/5c", o1_out, o8_out);
      end
   endtask

   task automatic test_wide_sweep();
      logic [7:0] pat [4];
      pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hF0; pat[3] = 8'h0F;
      b0 = pat[0]; b1 = pat[1]; b2 = pat[2]; b3 = pat[3];
      en = 1'b0;
      for (int sel = 0; sel < 4; sel++) begin
         {s1, s0} = sel[1:0];
         #1;
         checks++;
         if (o8_comb !== pat[sel] || o4_comb !== pat[sel][3:0]) begin
            failures++;
            $display("FAIL wide_comb sel=%0d: got %h/%h want %h", sel, o8_comb, o4_comb, pat[sel]);
         end
         @(posedge clk); #1;
         checks++;
         if (o8_out !== pat[sel]) begin
            failures++;
            $display("FAIL wide_reg sel=%0d: got %h want %h", sel, o8_out, pat[sel]);
         end
      end
      en = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o8_comb !== 8'h00 || o8_out !== 8'h00) begin
         failures++;
         $display("FAIL wide_disabled: got %h/%h want 00/00", o8_comb, o8_out);
      end
   endtask

   task automatic test_exhaustive();
      logic [6:0] v;
      logic [7:0] exp_c;
      for (int i = 0; i < 128; i++) begin
         v = i[6:0];
         en = v[6]; s1 = v[5]; s0 = v[4];
         a3 = v[3]; a2 = v[2]; a1 = v[1]; a0 = v[0];
         exp_c = model(v[6], v[5:4], {7'b0, v[0]}, {7'b0, v[1]}, {7'b0, v[2]}, {7'b0, v[3]}, 8'h00);
         #1;
         checks++;
         if (o1_comb !== exp_c[0]) begin
            failures++;
            $display("FAIL exh_comb vec=%b: got %b want %b", v, o1_comb, exp_c[0]);
         end
         @(posedge clk); #1;
         checks++;
         if (o1_out !== exp_c[0]) begin
            failures++;
            $display("FAIL exh_reg vec=%b: got %b want %b", v, o1_out, exp_c[0]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp8, exp4;
      for (int i = 0; i < 60; i++) begin
         en = ($urandom_range(3) == 0);
         {s1, s0} = 2'($urandom_range(3));
         b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
         exp8 = model(en, {s1, s0}, b0, b1, b2, b3, 8'h00);
         exp4 = model(en, {s1, s0}, b0, b1, b2, b3, DIS4);
         #1;
         checks++;
         if (o8_comb !== exp8 || o4_comb !== exp4[3:0]) begin
            failures++;
            $display("FAIL rand_comb i=%0d: got %h/%h want %h/%h", i, o8_comb, o4_comb, exp8, exp4[3:0]);
         end
         @(posedge clk); #1;
         checks++;
         if (o8_out !== exp8 || o4_out !== exp4[3:0]) begin
            failures++;
            $display("FAIL rand_reg i=%0d: got %h/%h want %h/%h", i, o8_out, o4_out, exp8, exp4[3:0]);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_toggle_track();
      test_disabled();
      test_enable_transition();
      test_reset_mid();
      test_wide_sweep();
      test_exhaustive();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mux_4to1
